axi_burst_master: RTL and testbench
===================================

// Module: axi_burst_master
// PURPOSE
//  AXI3 initiator that drives an axi_memory-style slave over axi_inf signals. Turns one
//  simple command (read or write, INCR burst) into AR/R or AW/W/B traffic.
//  One transaction in flight; write data streams in and read data streams out on
//  valid/ready ports. Sits between a local engine and the AXI slave port.
// PARAMETERS
//  ADDR_W  32  AXI address width
//  DATA_W  32  AXI data width (bytes = DATA_W/8, power of 2)
//  ID_W    4   AXI ID width
//  TMO_CYC 256 response watchdog limit in cycles (used only with the watchdog macro)
// PORTS
//  aclk                                  in   1       clock, rising edge
//  arst                                  in   1       synchronous reset, active-low
//  cmd_valid/cmd_ready                   in/out 1     command handshake
//  cmd_write                             in   1       1=write burst, 0=read burst
//  cmd_addr / cmd_len / cmd_id           in   ADDR_W/4/ID_W  start addr, beats-1, ID
//  wr_valid/wr_ready, wr_data            in/out/in 1/1/DATA_W  write payload stream
//  rd_valid/rd_ready, rd_data, rd_last   out/in/out/out 1/1/DATA_W/1  read payload
//  done_valid, done_resp, done_id        out  1/2/ID_W  completion pulse + BRESP/worst RRESP
//  awid,awaddr,awlen,awsize,awburst      out  ID_W,ADDR_W,4,3,2  AW payload
//  awlock,awcache,awprot                 out  2,4,3   constant 0
//  awvalid/awready                       out/in 1     AW handshake
//  wid,wdata,wstrb,wlast,wvalid / wready out/in ID_W,DATA_W,DATA_W/8,1,1 / 1
//  bid,bresp,bvalid / bready             in/out ID_W,2,1 / 1
//  arid,araddr,arlen,arsize,arburst      out  ID_W,ADDR_W,4,3,2  AR payload
//  arlock,arcache,arprot                 out  2,4,3   constant 0
//  arvalid/arready                       out/in 1     AR handshake
//  rid,rdata,rresp,rlast,rvalid / rready in/out ID_W,DATA_W,2,1,1 / 1
// BEHAVIOUR
//  - Reset: arst sampled low at aclk edge -> state IDLE. All valid/ready outputs 0.
//    All AXI payload outputs 0. done_* 0. Beat counter 0. Mid-burst reset abandons
//    the transfer with no completion.
//  - FSM: IDLE->AW (cmd_write)|AR (!cmd_write) on cmd_valid&&cmd_ready.
//    AW->W on awready. W->B on the last W beat accepted. B->IDLE on bvalid.
//    AR->R on arready. R->IDLE on rvalid&&rready&&rlast.
//  - cmd_ready=1 only in IDLE. The command is registered on acceptance.
//    awvalid/arvalid rise the next cycle.
//  - Payload held stable while valid && !ready (AXI rule). burst=2'b01 INCR,
//    size=log2(DATA_W/8), len=cmd_len, id=cmd_id.
//  - W: wvalid=wr_valid, wr_ready=wready in state W (combinational pass-through),
//    wid=cmd_id, wstrb all ones. wlast=1 when beat count==cmd_len. Count increments
//    per accepted beat (4-bit, max 16 beats, no wrap).
//  - B: bready=1 in B. On bvalid: done_valid pulses 1 cycle, done_resp=bresp, done_id=bid.
//  - R: rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=rlast. Worst rresp
//    is accumulated. On the last beat: done_valid pulse with done_resp=that max.
//  - rid or bid != cmd_id: done_resp forced 2'b10 (SLVERR).
//  - Early rlast (before beat cmd_len) ends the burst; done_resp=2'b10.
//    A missing rlast past cmd_len beats is also reported as 2'b10 at rlast.
//  - The only latency is register-boundary: cmd->AW/AR 1 cycle, last response->
//    done_valid 1 cycle, done->cmd_ready 1 cycle.
// CONFIGURATION
//  AXI_MASTER_WATCHDOG_EN defined: a cycle counter runs in states B and R and clears
//    on every handshake.
//    At TMO_CYC it forces done_valid with done_resp=2'b11, drops bready/rready and
//    returns to IDLE.
//  Undefined: no counter; the master waits indefinitely for B/R.
// TESTING
//  1. Write addr 0x100 len 3 data 1..4, slave awready delayed 2 cycles -> awlen=3,
//     awsize=2, awburst=1. wlast only on 4th beat. done_resp=0, memory reads back 1..4.
//  2. Read addr 0x100 len 3 with rd_ready toggling 1/0 -> rd_data 1,2,3,4 in order,
//     rd_last on beat 4, no beat lost or duplicated.
//  3. Reset (arst=0) asserted in state W after beat 2 -> next cycle all valids 0,
//     cmd_ready=1 after release, no done_valid.
//  4. Slave returns rresp=2'b10 on beat 2 of 4 -> done_resp=2'b10; bid!=cmd_id
//     -> done_resp=2'b10.
//  5. Back-to-back write then read commands -> second cmd_ready exactly 1 cycle
//     after first done_valid; AW/AR never both valid.
//  6. (WATCHDOG_EN, TMO_CYC=16) bvalid never asserted -> done_valid at 16 cycles
//     with done_resp=2'b11, FSM in IDLE.

Source files
------------

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI3 INCR burst initiator (cmd -> AW/W/B or AR/R).
// Optional AXI_MASTER_WATCHDOG_EN adds a TMO_CYC response timeout in B and R.
module axi_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int TMO_CYC = 256
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done_valid,
  output logic [1:0]          done_resp,
  output logic [ID_W-1:0]     done_id,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);
  localparam logic [2:0] SZ = 3'($clog2(DATA_W/8));
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;
  state_t r_state, w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0] r_len, r_cnt;
  logic [ID_W-1:0] r_id, r_done_id;
  logic [1:0] r_racc, r_done_resp, w_rmax;
  logic r_rerr, r_done_valid, r_run;
  logic w_cmd_hs, w_w_hs, w_b_hs, w_r_hs, w_r_end, w_r_bad, w_tmo;
  assign w_cmd_hs = cmd_valid && cmd_ready;
  assign w_w_hs   = wvalid && wready;
  assign w_b_hs   = bvalid && bready;
  assign w_r_hs   = rvalid && rready;
  assign w_r_end  = w_r_hs && rlast;
  assign w_rmax   = rresp > r_racc ? rresp : r_racc;
  // Short or overlong bursts both show up as a count mismatch or a flagged overrun.
  assign w_r_bad  = r_rerr || rid != r_id || r_cnt != r_len;
`ifdef AXI_MASTER_WATCHDOG_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] r_tmo;
  logic w_wait;
  assign w_wait = (r_state == B && !w_b_hs) || (r_state == R && !w_r_hs);
  assign w_tmo  = w_wait && r_tmo == TW'(TMO_CYC - 1);
  always_ff @(posedge aclk)
    r_tmo <= (!arst || !w_wait || w_tmo) ? '0 : r_tmo + TW'(1);
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = w_cmd_hs ? (cmd_write ? AW : AR) : IDLE;
      AW:      w_nxt = awready ? W : AW;
      W:       w_nxt = w_w_hs && wlast ? B : W;
      B:       w_nxt = w_b_hs || w_tmo ? IDLE : B;
      AR:      w_nxt = arready ? R : AR;
      R:       w_nxt = w_r_end || w_tmo ? IDLE : R;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (!arst) begin
      r_state      <= IDLE;
      r_run        <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_id         <= '0;
      r_cnt        <= '0;
      r_racc       <= '0;
      r_rerr       <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_resp  <= '0;
      r_done_id    <= '0;
    end else begin
      r_state      <= w_nxt;
      r_run        <= 1'b1;
      r_done_valid <= w_b_hs || w_r_end || w_tmo;
      if (w_cmd_hs) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_id   <= cmd_id;
        r_cnt  <= '0;
        r_racc <= '0;
        r_rerr <= 1'b0;
      end
      if (w_w_hs || w_r_hs) r_cnt <= r_cnt == 4'hf ? r_cnt : r_cnt + 4'd1;
      if (w_r_hs) begin
        r_racc <= w_rmax;
        r_rerr <= r_rerr || rid != r_id || (r_cnt == r_len && !rlast);
      end
      if (w_b_hs) begin
        r_done_resp <= bid != r_id ? 2'b10 : bresp;
        r_done_id   <= bid;
      end
      if (w_r_end) begin
        r_done_resp <= w_r_bad ? 2'b10 : w_rmax;
        r_done_id   <= rid;
      end
      if (w_tmo) begin
        r_done_resp <= 2'b11;
        r_done_id   <= r_id;
      end
    end
  end
  // Ready is withheld during reset and for the cycle that carries the done pulse.
  assign cmd_ready  = r_state == IDLE && !r_done_valid && r_run;
  assign done_valid = r_done_valid;
  assign done_resp  = r_done_resp;
  assign done_id    = r_done_id;
  assign awid    = r_id;
  assign awaddr  = r_addr;
  assign awlen   = r_len;
  assign awsize  = r_state == AW ? SZ : 3'd0;
  assign awburst = r_state == AW ? 2'b01 : 2'b00;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = r_state == AW;
  assign wid      = r_id;
  assign wdata    = r_state == W ? wr_data : '0;
  assign wstrb    = r_state == W ? '1 : '0;
  assign wlast    = r_state == W && r_cnt == r_len;
  assign wvalid   = r_state == W && wr_valid;
  assign wr_ready = r_state == W && wready;
  assign bready   = r_state == B;
  assign arid    = r_id;
  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arsize  = r_state == AR ? SZ : 3'd0;
  assign arburst = r_state == AR ? 2'b01 : 2'b00;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = r_state == AR;
  assign rready   = r_state == R && rd_ready;
  assign rd_valid = r_state == R && rvalid;
  assign rd_data  = r_state == R ? rdata : '0;
  assign rd_last  = r_state == R && rlast;
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: random + directed bursts against an in-bench AXI slave and a
// queue-based reference model; a monitor pops expected read beats and completions.
module tb_axi_burst_master;
`ifdef AXI_MASTER_WATCHDOG_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif
  logic clk = 1'b0, arst = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
  logic [31:0] cmd_addr, wr_data, rd_data, awaddr, wdata, araddr, rdata;
  logic [3:0] cmd_len, cmd_id, done_id, awid, awlen, awcache, wid, wstrb, bid, arid, arlen, arcache, rid;
  logic [1:0] done_resp, awburst, awlock, bresp, arburst, arlock, rresp;
  logic [2:0] awsize, awprot, arsize, arprot;
  logic done_valid, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  axi_burst_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .TMO_CYC(TMO)) dut (
    .aclk(clk), .arst(arst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp), .done_id(done_id), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    int aw_dly; int rbeat; logic [1:0] rval; logic [1:0] bresp; bit bad_id; int early; bit no_b;
    logic [31:0] addr; logic [3:0] len; logic [3:0] id;
  } cfg_t;
  typedef struct { logic [31:0] d; logic l; } rd_t;
  typedef struct { logic [1:0] r; logic [3:0] id; } dn_t;
  cfg_t cfg_q[$];
  logic [31:0] wq[$];
  rd_t exp_rd[$];
  dn_t exp_dn[$];
  logic [31:0] ref_mem[int unsigned], slv_mem[int unsigned];
  logic [31:0] wbuf[16];
  int vec = 0, mis = 0, cyc = 0, w_beats = 0, b_start = 0;
  bit abort = 0, toggle_rd = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction
  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : ~a;
  endfunction
  function automatic cfg_t dflt();
    cfg_t c;
    c.aw_dly = 0; c.rbeat = -1; c.rval = 0; c.bresp = 0; c.bad_id = 0; c.early = -1; c.no_b = 0;
    c.addr = 0; c.len = 0; c.id = 0;
    return c;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tmo_fail(input string n);
    mis++;
    $display("FAIL %s: timed out", n);
  endtask

  // Reference model: derive expected read stream and completion from the command alone.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                       input cfg_t c, input int ndat, input bit exp_done);
    dn_t d;
    rd_t r;
    logic [1:0] worst;
    int nb, n;
    c.addr = addr; c.len = len; c.id = id;
    cfg_q.push_back(c);
    if (wr) begin
      for (int i = 0; i < ndat; i++) begin
        wq.push_back(wbuf[i]);
        if (exp_done) ref_mem[addr + 4 * i] = wbuf[i];
      end
      d.r = c.bad_id ? 2'b10 : c.bresp;
    end else begin
      nb = c.early >= 0 ? c.early + 1 : int'(len) + 1;
      worst = 2'b00;
      for (int i = 0; i < nb; i++) begin
        r.d = ref_rd(addr + 4 * i);
        r.l = i == nb - 1;
        exp_rd.push_back(r);
        if (i == c.rbeat && c.rval > worst) worst = c.rval;
      end
      d.r = (c.bad_id || nb != int'(len) + 1) ? 2'b10 : worst;
    end
    if (c.no_b) d.r = 2'b11;
    d.id = c.bad_id ? id ^ 4'd1 : id;
    if (exp_done) exp_dn.push_back(d);
    @(negedge clk);
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) tmo_fail("cmd_ready");
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_dn.size() > 0 || exp_rd.size() > 0 || cfg_q.size() > 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) tmo_fail("completion");
    @(negedge clk);
  endtask

  // AXI slave: drives at negedge+1 after sampling the master's valids.
  initial begin : slave
    cfg_t c;
    int n, nb;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    forever begin
      @(negedge clk); #1;
      if ((awvalid || arvalid) && cfg_q.size() > 0) begin
        c = cfg_q.pop_front();
        repeat (c.aw_dly) begin @(negedge clk); #1; end
        if (awvalid) begin
          awready = 1;
          chk("awaddr", awaddr, c.addr);
          chk("awlen", awlen, c.len);
          chk("awid", awid, c.id);
          chk("awsize/burst", {awsize, awburst}, {3'd2, 2'b01});
          chk("aw consts", {awlock, awcache, awprot}, 0);
          @(negedge clk); #1;
          awready = 0;
          n = 0;
          while (n <= int'(c.len) && !abort) begin
            wready = $urandom_range(0, 3) != 0;
            if (wvalid && wready) begin
              chk("wlast", wlast, n == int'(c.len));
              chk("wid/wstrb", {wid, wstrb}, {c.id, 4'hf});
              slv_mem[c.addr + 4 * n] = wdata;
              n++;
              w_beats = n;
              if (n > int'(c.len)) b_start = cyc + 1;
            end
            @(negedge clk); #1;
          end
          wready = 0;
          if (!abort && !c.no_b) begin
            bvalid = 1; bid = c.bad_id ? c.id ^ 4'd1 : c.id; bresp = c.bresp;
            while (!bready) begin @(negedge clk); #1; end
            @(negedge clk); #1;
            bvalid = 0;
          end
        end else begin
          arready = 1;
          chk("araddr", araddr, c.addr);
          chk("arlen", arlen, c.len);
          chk("arid", arid, c.id);
          chk("arsize/burst", {arsize, arburst}, {3'd2, 2'b01});
          @(negedge clk); #1;
          arready = 0;
          nb = c.early >= 0 ? c.early + 1 : int'(c.len) + 1;
          for (int i = 0; i < nb; i++) begin
            rvalid = 1; rdata = slv_rd(c.addr + 4 * i); rlast = i == nb - 1;
            rresp = i == c.rbeat ? c.rval : 2'b00;
            rid = c.bad_id ? c.id ^ 4'd1 : c.id;
            while (!rready) begin @(negedge clk); #1; end
            @(negedge clk); #1;
          end
          rvalid = 0; rlast = 0;
        end
      end
    end
  end

  initial begin : wsrc
    wr_valid = 0; wr_data = 0;
    forever begin
      @(negedge clk);
      if (abort) wq.delete();
      wr_valid = wq.size() > 0 && $urandom_range(0, 3) != 0;
      if (wq.size() > 0) wr_data = wq[0];
      #2;
      if (wr_valid && wr_ready) void'(wq.pop_front());
    end
  end

  initial begin : rsink
    rd_t r;
    rd_ready = 0;
    forever begin
      @(negedge clk);
      rd_ready = toggle_rd ? ~rd_ready : ($urandom_range(0, 3) != 0);
      #2;
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          mis++;
          $display("FAIL rd beat: unexpected data %0h", rd_data);
        end else begin
          r = exp_rd.pop_front();
          chk("rd_data", rd_data, r.d);
          chk("rd_last", rd_last, r.l);
        end
      end
    end
  end

  initial begin : mon
    dn_t d;
    forever begin
      @(negedge clk); #2;
      if (awvalid && arvalid) begin
        mis++;
        $display("FAIL aw/ar overlap: both valid at cycle %0d", cyc);
      end
      if (done_valid) begin
        if (exp_dn.size() == 0) begin
          mis++;
          $display("FAIL done: unexpected pulse resp %0h", done_resp);
        end else begin
          d = exp_dn.pop_front();
          chk("done_resp", done_resp, d.r);
          chk("done_id", done_id, d.id);
        end
      end
    end
  end

  initial begin : guard
    #500000;
    mis++;
    $display("FAIL global: simulation time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $fatal(1, "time limit");
  end

  initial begin : main
    cfg_t c;
    int n, sel;
    logic [3:0] len;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    repeat (3) @(negedge clk);
    chk("reset valids", {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid, rready, rd_valid, done_valid}, 0);
    chk("reset payload", {awaddr, awlen, awsize, awburst, arsize, done_resp, done_id}, 0);
    arst = 1;
    @(negedge clk);
    chk("cmd_ready after reset", cmd_ready, 1);
    // write 1..4 with delayed awready, then read it back with toggling rd_ready
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    c = dflt(); c.aw_dly = 2;
    issue(1, 32'h100, 3, 4'd5, c, 4, 1);
    wait_idle();
    toggle_rd = 1;
    issue(0, 32'h100, 3, 4'd6, dflt(), 0, 1);
    wait_idle();
    toggle_rd = 0;
    // error responses
    c = dflt(); c.rbeat = 1; c.rval = 2'b10;
    issue(0, 32'h100, 3, 4'd3, c, 0, 1);
    c = dflt(); c.bad_id = 1;
    issue(1, 32'h140, 1, 4'd9, c, 2, 1);
    wait_idle();
    // back-to-back: cmd_ready returns exactly one cycle after done
    wbuf[0] = 32'hdead_0001; wbuf[1] = 32'hdead_0002;
    issue(1, 32'h200, 1, 4'd1, dflt(), 2, 1);
    n = 0;
    while (!done_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo_fail("b2b done");
    chk("cmd_ready during done", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready after done", cmd_ready, 1);
    issue(0, 32'h200, 1, 4'd2, dflt(), 0, 1);
    wait_idle();
    // reset in W after two beats: transfer abandoned, no completion
    w_beats = 0;
    issue(1, 32'h800, 3, 4'd2, dflt(), 2, 0);
    n = 0;
    while (w_beats < 2 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo_fail("w beats");
    arst = 0; abort = 1;
    @(negedge clk);
    chk("mid-burst reset valids", {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid, rready, done_valid}, 0);
    arst = 1;
    @(negedge clk);
    @(negedge clk);
    abort = 0;
    chk("cmd_ready after mid reset", {cmd_ready, done_valid}, 2'b10);
`ifdef AXI_MASTER_WATCHDOG_EN
    c = dflt(); c.no_b = 1;
    issue(1, 32'h300, 1, 4'd7, c, 2, 1);
    n = 0;
    while (!done_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo_fail("watchdog done");
    chk("watchdog latency", cyc - b_start, 16);
    @(negedge clk);
    chk("idle after watchdog", cmd_ready, 1);
    wait_idle();
`endif
    for (int k = 0; k < 24; k++) begin
      c = dflt();
      len = 4'($urandom_range(0, 15));
      c.aw_dly = $urandom_range(0, 3);
      sel = $urandom_range(0, 7);
      if (sel == 0) c.bad_id = 1;
      if (sel == 1) begin c.rbeat = $urandom_range(0, int'(len)); c.rval = 2'($urandom_range(1, 3)); end
      if (sel == 2) c.early = $urandom_range(0, int'(len));
      if (sel == 3) c.bresp = 2'($urandom_range(1, 3));
      if (sel == 4) c.early = int'(len) + 1;
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      issue(k % 3 == 0 || sel == 3, 32'($urandom_range(0, 127) * 4), len, 4'($urandom_range(0, 15)), c,
            int'(len) + 1, 1);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
